// File: rtl/uart_cmd_parser.sv
// Framed command parser behind a UART receiver: sync, cmd, len, payload, xor.
// Verified commands are held on a valid/ack port; framing faults pulse o_err.
module uart_cmd_parser #(
  parameter int unsigned MAX_PAYLOAD  = 8,
  parameter logic [7:0]  SYNC_BYTE    = 8'hA5,
  parameter int unsigned TIMEOUT_CLKS = 8680
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     i_rx_dv,
  input  logic [7:0]               i_rx_byte,
  input  logic                     i_cmd_ack,
  output logic                     o_cmd_valid,
  output logic [7:0]               o_cmd,
  output logic [3:0]               o_len,
  output logic [MAX_PAYLOAD*8-1:0] o_payload,
  output logic                     o_err,
  output logic [1:0]               o_err_code
);

  localparam int unsigned PW = MAX_PAYLOAD * 8;
  localparam int unsigned CW = $clog2(TIMEOUT_CLKS);
  localparam logic [CW-1:0] TO_LAST = CW'(TIMEOUT_CLKS - 2);
  localparam logic [7:0] MAX_LEN = 8'(MAX_PAYLOAD);

  typedef enum logic [2:0] {
    S_IDLE, S_CMD, S_LEN, S_PAYLOAD, S_CHK
  } state_t;

  state_t          state_q, state_d;
  logic [7:0]      wcmd_q, wcmd_d;
  logic [3:0]      wlen_q, wlen_d;
  logic [3:0]      idx_q, idx_d;
  logic [7:0]      chk_q, chk_d;
  logic [PW-1:0]   buf_q, buf_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            valid_q, valid_d;
  logic [7:0]      cmd_q, cmd_d;
  logic [3:0]      len_q, len_d;
  logic [PW-1:0]   pay_q, pay_d;
  logic            err_q, err_d;
  logic [1:0]      code_q, code_d;

  always_comb begin
    state_d = state_q;
    wcmd_d  = wcmd_q;
    wlen_d  = wlen_q;
    idx_d   = idx_q;
    chk_d   = chk_q;
    buf_d   = buf_q;
    cnt_d   = cnt_q;
    valid_d = valid_q & ~i_cmd_ack;
    cmd_d   = cmd_q;
    len_d   = len_q;
    pay_d   = pay_q;
    err_d   = 1'b0;
    code_d  = code_q;
    if (i_rx_dv) begin
      cnt_d = '0;
      unique case (state_q)
        S_IDLE: begin
          if (i_rx_byte == SYNC_BYTE) state_d = S_CMD;
        end
        S_CMD: begin
          wcmd_d  = i_rx_byte;
          chk_d   = i_rx_byte;
          state_d = S_LEN;
        end
        S_LEN: begin
          if (i_rx_byte > MAX_LEN) begin
            err_d   = 1'b1;
            code_d  = 2'b01;
            state_d = S_IDLE;
          end else begin
            wlen_d  = i_rx_byte[3:0];
            chk_d   = chk_q ^ i_rx_byte;
            idx_d   = '0;
            state_d = (i_rx_byte == 8'h00) ? S_CHK : S_PAYLOAD;
          end
        end
        S_PAYLOAD: begin
          buf_d[{idx_q, 3'b000} +: 8] = i_rx_byte;
          chk_d = chk_q ^ i_rx_byte;
          if (idx_q == wlen_q - 4'd1) state_d = S_CHK;
          else idx_d = idx_q + 4'd1;
        end
        S_CHK: begin
          state_d = S_IDLE;
          if (i_rx_byte != chk_q) begin
            err_d  = 1'b1;
            code_d = 2'b10;
          end else if (!valid_q || i_cmd_ack) begin
            valid_d = 1'b1;
            cmd_d   = wcmd_q;
            len_d   = wlen_q;
            for (int k = 0; k < int'(MAX_PAYLOAD); k++)
              pay_d[8*k +: 8] = (k < int'(wlen_q)) ? buf_q[8*k +: 8] : 8'h00;
          end else begin
            // consumer still holds the previous command: drop this one
            err_d  = 1'b1;
            code_d = 2'b00;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end else if (state_q != S_IDLE) begin
      if (cnt_q == TO_LAST) begin
        err_d   = 1'b1;
        code_d  = 2'b11;
        state_d = S_IDLE;
        cnt_d   = '0;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      wcmd_q  <= '0;
      wlen_q  <= '0;
      idx_q   <= '0;
      chk_q   <= '0;
      buf_q   <= '0;
      cnt_q   <= '0;
      valid_q <= 1'b0;
      cmd_q   <= '0;
      len_q   <= '0;
      pay_q   <= '0;
      err_q   <= 1'b0;
      code_q  <= '0;
    end else begin
      state_q <= state_d;
      wcmd_q  <= wcmd_d;
      wlen_q  <= wlen_d;
      idx_q   <= idx_d;
      chk_q   <= chk_d;
      buf_q   <= buf_d;
      cnt_q   <= cnt_d;
      valid_q <= valid_d;
      cmd_q   <= cmd_d;
      len_q   <= len_d;
      pay_q   <= pay_d;
      err_q   <= err_d;
      code_q  <= code_d;
    end
  end

  assign o_cmd_valid = valid_q;
  assign o_cmd       = cmd_q;
  assign o_len       = len_q;
  assign o_payload   = pay_q;
  assign o_err       = err_q;
  assign o_err_code  = code_q;

endmodule

// File: tb/tb_uart_cmd_parser.sv
// Randomized and directed bench for uart_cmd_parser with a frame-level model.
// The model works on whole byte queues and cycle stamps, not parser states.
module tb_uart_cmd_parser;

  localparam int MAXP = 8;
  localparam int TO   = 8680;
  localparam logic [7:0] SYNC = 8'hA5;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            dv  = 1'b0;
  logic [7:0]      rxb = 8'h00;
  logic            ack = 1'b0;
  logic            o_cmd_valid;
  logic [7:0]      o_cmd;
  logic [3:0]      o_len;
  logic [MAXP*8-1:0] o_payload;
  logic            o_err;
  logic [1:0]      o_err_code;

  int checks = 0;
  int errors = 0;

  always #10 clk = ~clk;

  uart_cmd_parser #(
    .MAX_PAYLOAD (MAXP),
    .SYNC_BYTE   (SYNC),
    .TIMEOUT_CLKS(TO)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .i_rx_dv    (dv),
    .i_rx_byte  (rxb),
    .i_cmd_ack  (ack),
    .o_cmd_valid(o_cmd_valid),
    .o_cmd      (o_cmd),
    .o_len      (o_len),
    .o_payload  (o_payload),
    .o_err      (o_err),
    .o_err_code (o_err_code)
  );

  task automatic chk(input string nm, input logic [95:0] act,
                     input logic [95:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got=%h want=%h", nm, act, exp);
    end
  endtask

  // frame-level reference model
  bit          started = 0;
  bit          in_frame = 0;
  logic [7:0]  fr[$];
  longint      cyc = 0;
  longint      last_dv = 0;
  logic        e_valid = 0;
  logic [7:0]  e_cmd = 0;
  logic [3:0]  e_len = 0;
  logic [MAXP*8-1:0] e_pay = '0;
  logic        e_err = 0;
  logic [1:0]  e_code = 0;
  logic        nv;
  logic [7:0]  x;

  task automatic flag(input logic [1:0] c);
    e_err    = 1'b1;
    e_code   = c;
    in_frame = 0;
  endtask

  always @(posedge clk) begin
    cyc++;
    e_err = 1'b0;
    if (rst) begin
      started  = 1;
      in_frame = 0;
      fr.delete();
      e_valid = 0; e_cmd = 0; e_len = 0; e_pay = '0; e_code = 0;
    end else begin
      nv = e_valid && !ack;
      if (dv) begin
        last_dv = cyc;
        if (!in_frame) begin
          if (rxb == SYNC) begin
            in_frame = 1;
            fr.delete();
          end
        end else begin
          fr.push_back(rxb);
          if (fr.size() == 2 && int'(fr[1]) > MAXP) begin
            flag(2'b01);
          end else if (fr.size() >= 2 && fr.size() == int'(fr[1]) + 3) begin
            x = 8'h00;
            for (int i = 0; i < fr.size() - 1; i++) x ^= fr[i];
            if (x != fr[fr.size()-1]) flag(2'b10);
            else if (!e_valid || ack) begin
              e_cmd = fr[0];
              e_len = fr[1][3:0];
              e_pay = '0;
              for (int k = 0; k < int'(fr[1]); k++) e_pay[8*k +: 8] = fr[2+k];
              nv = 1'b1;
            end else flag(2'b00);
            in_frame = 0;
          end
        end
      end else if (in_frame && (cyc - last_dv) == TO - 1) begin
        flag(2'b11);
      end
      e_valid = nv;
    end
  end

  always @(negedge clk) begin
    if (started)
      chk("cycle", {o_cmd_valid, o_cmd, o_len, o_payload, o_err, o_err_code},
          {e_valid, e_cmd, e_len, e_pay, e_err, e_code});
  end

  task automatic send(input logic [7:0] b, input logic a = 1'b0);
    dv = 1'b1; rxb = b; ack = a;
    @(negedge clk);
    dv = 1'b0; ack = 1'b0;
  endtask

  task automatic do_ack();
    ack = 1'b1;
    @(negedge clk);
    ack = 1'b0;
  endtask

  logic [7:0] tq[$];
  int k;

  task automatic gen_frame();
    logic [7:0] c, l, s, p;
    if ($urandom_range(0, 3) == 0) tq.push_back(8'h33);
    tq.push_back(SYNC);
    c = 8'($urandom);
    l = 8'($urandom_range(0, 10));
    tq.push_back(c);
    tq.push_back(l);
    s = c ^ l;
    if (l <= 8'(MAXP)) begin
      for (int i = 0; i < int'(l); i++) begin
        p = 8'($urandom);
        tq.push_back(p);
        s ^= p;
      end
      if ($urandom_range(0, 4) == 0) s ^= 8'h01;
      tq.push_back(s);
    end
  endtask

  initial begin
    @(negedge clk);
    @(negedge clk);
    chk("reset_valid", o_cmd_valid, 0);
    chk("reset_pay", {o_cmd, o_len, o_payload, o_err_code}, 0);
    rst = 1'b0;
    @(negedge clk);

    send(8'hA5); send(8'h10); send(8'h02); send(8'h11); send(8'h22); send(8'h21);
    chk("f1_valid", o_cmd_valid, 1);
    chk("f1_cmd", o_cmd, 8'h10);
    chk("f1_len", o_len, 4'd2);
    chk("f1_pay", o_payload, 64'h2211);
    do_ack();
    chk("f1_ack", o_cmd_valid, 0);

    send(8'h33); send(8'hA5); send(8'h05); send(8'h00); send(8'h05);
    chk("zlen", {o_cmd_valid, o_cmd, o_len, o_payload}, {1'b1, 8'h05, 4'd0, 64'h0});
    do_ack();

    send(8'hA5); send(8'h10); send(8'h02); send(8'h11); send(8'h22); send(8'h20);
    chk("badchk", {o_err, o_err_code, o_cmd_valid}, {1'b1, 2'b10, 1'b0});
    send(8'hA5); send(8'h10); send(8'h02); send(8'h11); send(8'h22); send(8'h21);
    chk("after_bad", {o_cmd_valid, o_cmd}, {1'b1, 8'h10});
    do_ack();

    send(8'hA5); send(8'h10); send(8'h09);
    chk("len_big", {o_err, o_err_code}, {1'b1, 2'b01});

    send(8'hA5); send(8'h10);
    k = 0;
    while (!o_err && k < TO + 100) begin
      @(negedge clk);
      k++;
    end
    chk("timeout_edge", k, TO - 1);
    chk("timeout_code", o_err_code, 2'b11);

    send(8'hA5); send(8'h10); send(8'h02); send(8'h11); send(8'h22); send(8'h21);
    send(8'hA5); send(8'h20); send(8'h01); send(8'h33); send(8'h12);
    chk("overrun", {o_err, o_err_code, o_cmd_valid, o_cmd},
        {1'b1, 2'b00, 1'b1, 8'h10});
    send(8'hA5); send(8'h30); send(8'h00); send(8'h30, 1'b1);
    chk("ack_reload", {o_err, o_cmd_valid, o_cmd, o_len}, {1'b0, 1'b1, 8'h30, 4'd0});
    do_ack();

    send(8'hA5); send(8'h40); send(8'h03); send(8'h01);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("mid_rst", {o_cmd_valid, o_cmd, o_len, o_payload, o_err, o_err_code}, 0);
    send(8'hA5); send(8'h50); send(8'h01); send(8'h77); send(8'h26);
    chk("post_rst", {o_cmd_valid, o_cmd, o_len, o_payload}, {1'b1, 8'h50, 4'd1, 64'h77});
    do_ack();

    for (int n = 0; n < 8000; n++) begin
      if (tq.size() == 0) gen_frame();
      ack = ($urandom_range(0, 3) == 0);
      if ($urandom_range(0, 2) != 0) begin
        dv  = 1'b1;
        rxb = tq.pop_front();
      end else begin
        dv  = 1'b0;
        rxb = 8'($urandom);
      end
      @(negedge clk);
    end
    dv = 1'b0;
    ack = 1'b0;
    repeat (5) @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/uart_cmd_parser.md
Name: uart_cmd_parser

Overview:
- Sits directly downstream of UART_Rx: consumes its byte-valid pulse and received byte.
- Assembles framed command packets from the byte stream: sync byte, command, length, payload, XOR checksum.
- Presents each checksum-verified command to the smartwatch control logic through a valid/ack handshake.
- Reports malformed, timed-out and overrun frames with a one-cycle error pulse and a 2-bit error code.

Parameters:
MAX_PAYLOAD, 8, maximum payload bytes per frame (1..15)
SYNC_BYTE, 8'hA5, frame start marker
TIMEOUT_CLKS, 8680, max clk cycles between bytes inside a frame (20 bit times at 115200 baud, 50 MHz)

Ports:
clk  input  1  system clock, 50 MHz, same clock as UART_Rx
rst  input  1  synchronous, active-high reset
i_rx_dv  input  1  one-cycle pulse, byte valid (from UART_Rx o_RX_DV)
i_rx_byte  input  8  received byte (from UART_Rx o_RX_Byte)
i_cmd_ack  input  1  consumer accepts current command
o_cmd_valid  output  1  command pending; held until acked
o_cmd  output  8  command byte
o_len  output  4  payload length, 0..MAX_PAYLOAD
o_payload  output  MAX_PAYLOAD*8  payload; byte k at [8k+7:8k]; unused bytes zero
o_err  output  1  one-cycle error pulse
o_err_code  output  2  00 overrun, 01 length too large, 10 checksum mismatch, 11 timeout; holds last code

Behaviour:
- Reset: state IDLE; o_cmd_valid=0, o_cmd=0, o_len=0, o_payload=0, o_err=0, o_err_code=0; working buffer, checksum and timeout counter cleared. Reset mid-frame discards the partial frame and any pending command.
- States: IDLE, CMD, LEN, PAYLOAD, CHK. Transitions occur only on an i_rx_dv cycle, except timeout.
  - IDLE: byte==SYNC_BYTE -> CMD. Any other byte is ignored silently.
  - CMD: latch working cmd; chk=byte -> LEN.
  - LEN: if byte > MAX_PAYLOAD -> o_err pulse, code 01, -> IDLE. Else latch len (low 4 bits); chk^=byte; len==0 -> CHK, else -> PAYLOAD with index=0.
  - PAYLOAD: store byte at working[index]; chk^=byte; index==len-1 -> CHK, else index++.
  - CHK: byte!=chk -> err code 10 -> IDLE. Match -> completion -> IDLE.
- SYNC_BYTE has no special meaning outside IDLE (no resync mid-frame).
- Completion:
  - If o_cmd_valid==0, or i_cmd_ack==1 in the same cycle: copy working cmd/len/payload (bytes >= len zeroed) into output registers; o_cmd_valid=1 from the next cycle. Latency is 1 clk after the checksum byte's i_rx_dv.
  - Otherwise (still pending, no ack): frame discarded, err code 00; outputs unchanged.
- Handshake: o_cmd_valid falls the cycle after i_cmd_ack=1 (unless a simultaneous completion reloads it). i_cmd_ack with o_cmd_valid=0 is ignored. Output registers change only on completion or reset, so they stay stable while valid.
- Parsing of the next frame continues while a command is pending.
- Timeout:
  - Counter counts in every non-IDLE state and clears on each i_rx_dv and on entry to IDLE.
  - When it reaches TIMEOUT_CLKS-1 without i_rx_dv: err code 11 -> IDLE.
  - If i_rx_dv arrives in that same cycle, the byte wins: it is processed and the counter clears.
- o_err is high for exactly one cycle per error; o_err_code updates in the same cycle and holds.
- Checksum is 8-bit XOR of the CMD, LEN and payload bytes. The sync byte is excluded.

Test Plan:
- Bytes A5 10 02 11 22 21 -> one cycle after the last byte: o_cmd_valid=1, o_cmd=10, o_len=2, o_payload[15:0]=2211, upper bytes 0, o_err never pulses. Ack -> valid=0 next cycle.
- Bytes 33 A5 05 00 05 (leading junk, zero length) -> o_cmd=05, o_len=0, o_payload=0, no error.
- A5 10 02 11 22 20 (bad checksum) -> o_err pulse, code 10, o_cmd_valid stays 0. Then a valid frame A5 10 02 11 22 21 is accepted.
- A5 10 09 -> err code 01 on the LEN byte, return to IDLE. A5 10 then 8680 idle clocks -> err code 11 exactly TIMEOUT_CLKS-1 clocks after the last i_rx_dv.
- Two valid frames, no ack -> second completion gives err code 00, outputs still hold frame 1. Ack asserted in the cycle of the second completion -> frame 2 loaded, valid stays 1, no error.
- Reset asserted mid-payload -> all outputs 0. A fresh frame afterwards parses correctly.
